// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back competes with a 2-entry FIFO of
// long-latency results. Define WB_ARB_FAIRNESS_EN to enable the starvation guard.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic        wb_mem_to_reg,
  input  logic [31:0] wb_mem_data,
  input  logic [31:0] wb_alu_result,
  input  logic        llu_valid,
  input  logic [4:0]  llu_rd,
  input  logic [31:0] llu_data,
  output logic        llu_ready,
  output logic        wb_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [1:0]  fifo_count
);

  typedef enum logic [1:0] {GntNone, GntPipe, GntFifo} grant_e;

  logic [1:0]  count_q;
  logic [4:0]  rd0_q, rd1_q;
  logic [31:0] data0_q, data1_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;

  grant_e grant;
  logic   fifo_nonempty, enq, pop;

  assign fifo_nonempty = (count_q != 2'd0);
  assign llu_ready     = ~rst & (count_q != 2'd2);
  // Accepted results for x0 are consumed but never stored.
  assign enq           = llu_valid & llu_ready & (llu_rd != 5'd0);
  assign pop           = (grant == GntFifo);

`ifdef WB_ARB_FAIRNESS_EN
  logic [3:0] starve_q;

  assign wb_stall = fifo_nonempty & (starve_q == 4'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else if (!fifo_nonempty || pop) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_q + 4'd1;
    end
  end
`else
  assign wb_stall = 1'b0;
`endif

  always_comb begin
    grant = GntNone;
    if (wb_stall) begin
      grant = GntFifo;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      grant = GntPipe;
    end else if (fifo_nonempty) begin
      grant = GntFifo;
    end
  end

  // Slot 0 is always the head; a pop shifts slot 1 forward so order is preserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      rd0_q   <= 5'd0;
      rd1_q   <= 5'd0;
      data0_q <= 32'd0;
      data1_q <= 32'd0;
    end else begin
      unique case ({enq, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            rd0_q   <= llu_rd;
            data0_q <= llu_data;
          end else begin
            rd1_q   <= llu_rd;
            data1_q <= llu_data;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          rd0_q   <= rd1_q;
          data0_q <= data1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Enqueue implies count < 2, and pop implies count > 0, so count is 1 here.
          rd0_q   <= llu_rd;
          data0_q <= llu_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      rf_we_q <= (grant != GntNone);
      if (grant == GntPipe) begin
        rf_waddr_q <= wb_rd;
        rf_wdata_q <= wb_mem_to_reg ? wb_mem_data : wb_alu_result;
      end else if (grant == GntFifo) begin
        rf_waddr_q <= rd0_q;
        rf_wdata_q <= data0_q;
      end
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a table of single-cycle vectors plus hand-written
// reset and starvation sequences. Honours WB_ARB_FAIRNESS_EN the same way as the design.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en, wb_mem_to_reg, llu_valid;
  logic [4:0]  wb_rd, llu_rd;
  logic [31:0] wb_mem_data, wb_alu_result, llu_data;
  logic        llu_ready, wb_stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_mem_data   (wb_mem_data),
    .wb_alu_result (wb_alu_result),
    .llu_valid     (llu_valid),
    .llu_rd        (llu_rd),
    .llu_data      (llu_data),
    .llu_ready     (llu_ready),
    .wb_stall      (wb_stall),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic        m2r;
    logic [31:0] mem;
    logic [31:0] alu;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        exp_ready;
    logic        exp_stall;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_count;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [4:0] rd, input logic m2r,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
    wb_en = en; wb_rd = rd; wb_mem_to_reg = m2r; wb_mem_data = mem; wb_alu_result = alu;
    llu_valid = lv; llu_rd = lrd; llu_data = ldata;
  endtask

  initial begin
    // en rd m2r mem alu | lv lrd ldata | ready stall we waddr wdata count
    vecs[0]  = '{1'b1, 5'd5, 1'b0, 32'h0, 32'h1234, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234, 2'd0};
    vecs[1]  = '{1'b1, 5'd6, 1'b1, 32'hBEEF, 32'h1, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 5'd6, 32'hBEEF, 2'd0};
    vecs[2]  = '{1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd7, 32'hCAFE,
                 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 2'd1};
    vecs[3]  = '{1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 5'd7, 32'hCAFE, 2'd0};
    vecs[4]  = '{1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 2'd0};
    vecs[5]  = '{1'b1, 5'd3, 1'b0, 32'h0, 32'h33, 1'b1, 5'd8, 32'h80,
                 1'b1, 1'b0, 1'b1, 5'd3, 32'h33, 2'd1};
    vecs[6]  = '{1'b1, 5'd3, 1'b0, 32'h0, 32'h34, 1'b1, 5'd10, 32'hA0,
                 1'b1, 1'b0, 1'b1, 5'd3, 32'h34, 2'd2};
    vecs[7]  = '{1'b1, 5'd3, 1'b0, 32'h0, 32'h35, 1'b1, 5'd11, 32'hB0,
                 1'b0, 1'b0, 1'b1, 5'd3, 32'h35, 2'd2};
    vecs[8]  = '{1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd11, 32'hB0,
                 1'b0, 1'b0, 1'b1, 5'd8, 32'h80, 2'd1};
    // Enqueue and pop on the same edge: count unchanged, order kept.
    vecs[9]  = '{1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd11, 32'hB0,
                 1'b1, 1'b0, 1'b1, 5'd10, 32'hA0, 2'd1};
    vecs[10] = '{1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b1, 5'd11, 32'hB0, 2'd0};
    vecs[11] = '{1'b1, 5'd0, 1'b0, 32'h0, 32'h99, 1'b1, 5'd0, 32'h77,
                 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 2'd0};
    vecs[12] = '{1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 2'd0};

    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset rf_we", 32'(rf_we), 32'd0);
    check("reset rf_waddr", 32'(rf_waddr), 32'd0);
    check("reset rf_wdata", rf_wdata, 32'd0);
    check("reset fifo_count", 32'(fifo_count), 32'd0);
    check("reset llu_ready", 32'(llu_ready), 32'd0);
    check("reset wb_stall", 32'(wb_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].wb_en, vecs[i].wb_rd, vecs[i].m2r, vecs[i].mem, vecs[i].alu,
            vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
      #1;
      check($sformatf("vec%0d llu_ready", i), 32'(llu_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d wb_stall", i), 32'(wb_stall), 32'(vecs[i].exp_stall));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rf_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].exp_waddr));
        check($sformatf("vec%0d rf_wdata", i), rf_wdata, vecs[i].exp_wdata);
      end
    end

    // Mid-operation reset with a full FIFO: everything clears at once, no stale write later.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd3, 1'b0, 32'h0, 32'h40 + 32'(i), 1'b1, 5'(12 + i), 32'h100 + 32'(i));
    end
    @(posedge clk);
    #1;
    check("prefill fifo_count", 32'(fifo_count), 32'd2);
    check("prefill rf_we", 32'(rf_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst fifo_count", 32'(fifo_count), 32'd0);
    check("async rst rf_we", 32'(rf_we), 32'd0);
    check("async rst llu_ready", 32'(llu_ready), 32'd0);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post rst %0d rf_we", i), 32'(rf_we), 32'd0);
      check($sformatf("post rst %0d fifo_count", i), 32'(fifo_count), 32'd0);
    end

    // One entry for rd=9 buffered while the pipeline writes rd=3 every cycle.
    @(negedge clk);
    drive(1'b1, 5'd3, 1'b0, 32'h0, 32'h300, 1'b1, 5'd9, 32'h999);
    @(posedge clk);
    #1;
    check("starve load count", 32'(fifo_count), 32'd1);
`ifdef WB_ARB_FAIRNESS_EN
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      drive(1'b1, 5'd3, 1'b0, 32'h0, 32'h300 + 32'(c), 1'b0, 5'd0, 32'h0);
      #1;
      check($sformatf("starve c%0d wb_stall", c), 32'(wb_stall), 32'(c == 5));
      @(posedge clk);
      #1;
      check($sformatf("starve c%0d rf_waddr", c), 32'(rf_waddr), (c == 5) ? 32'd9 : 32'd3);
      check($sformatf("starve c%0d rf_wdata", c), rf_wdata,
            (c == 5) ? 32'h999 : 32'h300 + 32'(c));
      check($sformatf("starve c%0d fifo_count", c), 32'(fifo_count), (c >= 5) ? 32'd0 : 32'd1);
    end
`else
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      drive(1'b1, 5'd3, 1'b0, 32'h0, 32'h300 + 32'(c), 1'b0, 5'd0, 32'h0);
      #1;
      check($sformatf("prio c%0d wb_stall", c), 32'(wb_stall), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("prio c%0d rf_waddr", c), 32'(rf_waddr), 32'd3);
      check($sformatf("prio c%0d fifo_count", c), 32'(fifo_count), 32'd1);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    check("prio drain rf_waddr", 32'(rf_waddr), 32'd9);
    check("prio drain rf_wdata", rf_wdata, 32'h999);
    check("prio drain fifo_count", 32'(fifo_count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive cycles a buffered long-latency result may wait before it is forced onto the port (range 1..15).
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wb_en  input  1  pipeline write-back request.
REQ-006 wb_rd  input  5  pipeline destination register.
REQ-007 wb_mem_to_reg  input  1  1 selects wb_mem_data; 0 selects wb_alu_result.
REQ-008 wb_mem_data  input  32  load result.
REQ-009 wb_alu_result  input  32  ALU result.
REQ-010 llu_valid  input  1  long-latency unit result valid.
REQ-011 llu_rd  input  5  long-latency unit destination register.
REQ-012 llu_data  input  32  long-latency unit result.
REQ-013 llu_ready  output  1  arbiter accepts llu_* this cycle.
REQ-014 wb_stall  output  1  pipeline must hold its wb_* inputs this cycle.
REQ-015 rf_we  output  1  register file write enable (registered).
REQ-016 rf_waddr  output  5  register file write address (registered).
REQ-017 rf_wdata  output  32  register file write data (registered).
REQ-018 fifo_count  output  2  number of buffered long-latency results (0..2).

Function
REQ-019 SHALL accept an llu transfer on any rising edge where llu_valid=1 and llu_ready=1.
REQ-020 SHALL assert llu_ready combinationally whenever fifo_count<2 and rst=0.
REQ-021 SHALL enqueue accepted llu results with llu_rd!=0 into a 2-entry in-order FIFO, and SHALL discard accepted results with llu_rd=0.
REQ-022 SHALL make a newly enqueued entry eligible for grant on the cycle after enqueue; there is no bypass.
REQ-023 SHALL decide the grant combinationally each cycle using these rules, in order:
- forced: wb_stall=1 -> FIFO head;
- pipeline: wb_en=1 and wb_rd!=0 -> pipeline;
- drain: FIFO non-empty -> FIFO head;
- otherwise: none.
REQ-024 SHALL drop a pipeline request with wb_rd=0 (no write, no stall).
REQ-025 SHALL register the granted write one cycle after the grant (latency 1), with rf_we=1 for exactly that cycle; pipeline data is the mux selected by wb_mem_to_reg.
REQ-026 SHALL pop the FIFO head on the edge at which it is granted.
REQ-027 SHALL, when an enqueue and a pop occur on the same edge, update the count by net zero and preserve order.
REQ-028 SHALL hold rf_we=0 on any cycle following a cycle with no grant.
REQ-029 SHALL never reorder FIFO entries; ordering between the two sources for the same rd is the issue stage's responsibility.
REQ-030 SHALL keep fifo_count equal to the registered FIFO occupancy.

Reset
REQ-031 SHALL, while rst=1 and asynchronously on its assertion, set rf_we=0, rf_waddr=0, rf_wdata=0, fifo_count=0, FIFO empty, starve counter=0, wb_stall=0 and llu_ready=0.
REQ-032 SHALL discard any buffered entries when reset is asserted mid-operation; no write occurs on the first edge after rst deasserts unless a grant was made that cycle.

Configuration
REQ-033 Macro WB_ARB_FAIRNESS_EN SHALL control the starvation guard.
REQ-034 With WB_ARB_FAIRNESS_EN defined, the block SHALL behave as follows:
- a 4-bit starve counter increments on each edge where the FIFO is non-empty and the head is not granted;
- the counter clears whenever the head is granted or the FIFO is empty;
- wb_stall=1 on any cycle where counter=STARVE_LIMIT and the FIFO is non-empty;
- on such a cycle, the head is granted and the pipeline request is ignored.
REQ-035 Without WB_ARB_FAIRNESS_EN, the block SHALL tie wb_stall to 0, give the pipeline strict priority and contain no starve counter.

Verification
REQ-036 Reset then single pipeline write: wb_en=1, wb_rd=5, wb_mem_to_reg=0, wb_alu_result=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234.
REQ-037 Idle pipeline, llu_valid=1, llu_rd=7, llu_data=0xCAFE for one cycle -> fifo_count=1, then a write to register 7 with 0xCAFE two cycles after acceptance, fifo_count=0.
REQ-038 Three back-to-back llu transfers while wb_en=1, wb_rd=3 continuously -> llu_ready=0 after two accepts, fifo_count=2, third held; all writes go to register 3 (fairness off).
REQ-039 Fairness on, STARVE_LIMIT=4, FIFO holding one entry for rd=9, wb_en=1 continuously -> wb_stall=1 in exactly the 5th cycle, that cycle's write targets register 9, then wb_stall=0.
REQ-040 wb_rd=0 with wb_en=1, and llu_rd=0 accepted -> rf_we stays 0 and fifo_count stays 0.
REQ-041 rst asserted with fifo_count=2 -> fifo_count=0, rf_we=0 immediately; no stale write after release.
